// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int N_IN_DEF = 4;
  localparam int N_MIN    = 2 ** N_IN_DEF;
  localparam int CNT_W    = 4;

  function automatic int n_min(input int n_in);
    return 1 << n_in;
  endfunction

  // err_cnt must be able to hold 2^N_IN, hence one extra bit
  function automatic int err_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweeper bus: control, expected/captured tables and the function-under-test hookup.
// Optional first-fail signals exist only when TT_FIRST_FAIL_EN is defined.
interface truth_table_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) ();
  import tt_pkg::*;

  localparam int NM = n_min(N_IN);

  logic                    start;
  logic [N_OUT*NM-1:0]     exp_tt;
  logic [N_OUT-1:0]        res;
  logic [N_IN-1:0]         vec;
  logic [N_IN-1:0]         m;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [err_w(N_IN)-1:0]  err_cnt;
  logic [N_OUT*NM-1:0]     tt;
`ifdef TT_FIRST_FAIL_EN
  logic [N_IN-1:0]         first_fail;
  logic                    first_fail_vld;
`endif

  modport master (
    output start, exp_tt, res,
    input  vec, m, busy, done, pass, err_cnt, tt
`ifdef TT_FIRST_FAIL_EN
    , input first_fail, first_fail_vld
`endif
  );

  modport slave (
    input  start, exp_tt, res,
    output vec, m, busy, done, pass, err_cnt, tt
`ifdef TT_FIRST_FAIL_EN
    , output first_fail, first_fail_vld
`endif
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable settle down-counter; zero_o flags that the applied vector has settled.
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every minterm into a combinational block, captures its truth tables and checks them.
// Define TT_FIRST_FAIL_EN to add first_fail / first_fail_vld reporting.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int NM = n_min(N_IN);
  localparam int EW = err_w(N_IN);
  localparam int TW = N_OUT * NM;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  M_LAST = N_IN'(NM - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] m_q, m_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [EW-1:0]   err_q, err_d;
  logic [TW-1:0]   tt_q, tt_d;

  logic            tmr_load, tmr_dec, tmr_zero;
  logic [NM-1:0]   onehot;
  logic [TW-1:0]   sel_mask, res_rep, tt_samp;
  logic [N_OUT-1:0] miss_v;
  logic            miss;

  tt_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Per-output slices: the current minterm's bit position in every table
  assign onehot = NM'(1) << m_q;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic [NM-1:0] exp_sl;
    assign exp_sl                 = bus.exp_tt[o*NM +: NM];
    assign sel_mask[o*NM +: NM]   = onehot;
    assign res_rep[o*NM +: NM]    = {NM{bus.res[o]}};
    assign miss_v[o]              = bus.res[o] ^ exp_sl[m_q];
  end

  assign tt_samp = (tt_q & ~sel_mask) | (res_rep & sel_mask);
  assign miss    = |miss_v;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    tt_d     = tt_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tt_d     = '0;
          err_d    = '0;
          m_d      = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) state_d = ST_SAMPLE;
        else          tmr_dec = 1'b1;
      end
      ST_SAMPLE: begin
        tt_d = tt_samp;
        if (miss) err_d = err_q + EW'(1);
        // pass is judged on the table including this final sample so it is valid with done
        if (m_q == M_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (tt_samp == bus.exp_tt);
        end else begin
          m_d      = m_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      tt_q    <= tt_d;
    end
  end

  assign bus.vec     = m_q;
  assign bus.m       = m_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;
  assign bus.tt      = tt_q;

`ifdef TT_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_q;
  logic            ffv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q  <= '0;
      ffv_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && bus.start) begin
      ff_q  <= '0;
      ffv_q <= 1'b0;
    end else if ((state_q == ST_SAMPLE) && miss && !ffv_q) begin
      ff_q  <= m_q;
      ffv_q <= 1'b1;
    end
  end

  assign bus.first_fail     = ff_q;
  assign bus.first_fail_vld = ffv_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: table-driven sweeps plus multi-cycle corner cases.
module tb_truth_table_sweeper;

  localparam logic [31:0] TT_GOLD = 32'h7F007F00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  truth_table_sweeper_if #(.N_IN(4), .N_OUT(2)) b1 ();
  truth_table_sweeper_if #(.N_IN(4), .N_OUT(2)) b3 ();

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  // Function under test: s = x&~(y&w&z), t = x&(~y|~w|~z); res[0]=s, res[1]=t
  function automatic logic [1:0] fut(input logic [3:0] v);
    logic x, y, w, z, s, t;
    {x, y, w, z} = v;
    s = x & ~(y & w & z);
    t = x & (~y | ~w | ~z);
    return {t, s};
  endfunction

  assign b1.res = fut(b1.vec);
  assign b3.res = fut(b3.vec);

  typedef struct {
    logic [31:0] exp_tt;
    logic        pass;
    int          err;
    logic [3:0]  ff;
    logic        ffv;
  } vec_t;

  typedef struct {
    logic [31:0] tt;
    logic        pass;
    int          err;
    int          done_cyc;
    logic [3:0]  ff;
    logic        ffv;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int done1 = 0;
  int done3 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitors: track vec hold lengths, pop and compare on each done
  int act1 = 0, last1 = 0, run1 = 0, seqbad1 = 0;
  int act3 = 0, last3 = 0, run3 = 0, seqbad3 = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (b1.busy) begin
      if (act1 == 0) begin
        act1 = 1; last1 = int'(b1.vec); run1 = 1;
        if (b1.vec != 4'd0) seqbad1++;
      end else if (int'(b1.vec) == last1) run1++;
      else begin
        if (int'(b1.vec) != last1 + 1 || run1 != 2) seqbad1++;
        last1 = int'(b1.vec); run1 = 1;
      end
    end else act1 = 0;
    if (b3.busy) begin
      if (act3 == 0) begin
        act3 = 1; last3 = int'(b3.vec); run3 = 1;
        if (b3.vec != 4'd0) seqbad3++;
      end else if (int'(b3.vec) == last3) run3++;
      else begin
        if (int'(b3.vec) != last3 + 1 || run3 != 4) seqbad3++;
        last3 = int'(b3.vec); run3 = 1;
      end
    end else act3 = 0;

    if (b1.done) begin
      done1++;
      if (q1.size() == 0) chk("d1_unexpected_done", 64'(1), 64'(0));
      else begin
        e = q1.pop_front();
        chk("d1_done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("d1_tt", 64'(b1.tt), 64'(e.tt));
        chk("d1_pass", 64'(b1.pass), 64'(e.pass));
        chk("d1_err_cnt", 64'(b1.err_cnt), 64'(e.err));
        chk("d1_busy_low_at_done", 64'(b1.busy), 64'(0));
        chk("d1_vec_seq", 64'(seqbad1 == 0 && last1 == 15 && run1 == 2), 64'(1));
`ifdef TT_FIRST_FAIL_EN
        chk("d1_first_fail", 64'(b1.first_fail), 64'(e.ff));
        chk("d1_first_fail_vld", 64'(b1.first_fail_vld), 64'(e.ffv));
`endif
      end
      seqbad1 = 0;
    end
    if (b3.done) begin
      done3++;
      if (q3.size() == 0) chk("d3_unexpected_done", 64'(1), 64'(0));
      else begin
        e = q3.pop_front();
        chk("d3_done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("d3_tt", 64'(b3.tt), 64'(e.tt));
        chk("d3_pass", 64'(b3.pass), 64'(e.pass));
        chk("d3_err_cnt", 64'(b3.err_cnt), 64'(e.err));
        chk("d3_vec_seq", 64'(seqbad3 == 0 && last3 == 15 && run3 == 4), 64'(1));
      end
      seqbad3 = 0;
    end
  end

  task automatic check_zero1(input string tag);
    chk({tag, "_vec"}, 64'(b1.vec), 64'(0));
    chk({tag, "_m"}, 64'(b1.m), 64'(0));
    chk({tag, "_busy"}, 64'(b1.busy), 64'(0));
    chk({tag, "_done"}, 64'(b1.done), 64'(0));
    chk({tag, "_pass"}, 64'(b1.pass), 64'(0));
    chk({tag, "_err_cnt"}, 64'(b1.err_cnt), 64'(0));
    chk({tag, "_tt"}, 64'(b1.tt), 64'(0));
`ifdef TT_FIRST_FAIL_EN
    chk({tag, "_first_fail"}, 64'(b1.first_fail), 64'(0));
    chk({tag, "_first_fail_vld"}, 64'(b1.first_fail_vld), 64'(0));
`endif
  endtask

  task automatic wait_done1(input int d0, input string tag);
    int n;
    n = 0;
    while (done1 == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done1 != d0), 64'(1));
  endtask

  task automatic sweep1(input vec_t v, input bit pulses);
    int acc, d0;
    exp_t e;
    b1.exp_tt = v.exp_tt;
    @(negedge clk);
    d0 = done1;
    b1.start = 1'b1;
    acc = cyc + 1;
    e = '{TT_GOLD, v.pass, v.err, acc + 32, v.ff, v.ffv};
    q1.push_back(e);
    @(negedge clk);
    b1.start = 1'b0;
    if (pulses) begin
      repeat (5) @(negedge clk);
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      repeat (14) @(negedge clk);
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
    end
    wait_done1(d0, "sweep1");
    if (pulses) begin
      repeat (40) @(negedge clk);
      chk("busy_start_single_done", 64'(done1 - d0), 64'(1));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    vec_t tv[6];
    exp_t e;
    int acc, d0, n;

    tv[0] = '{32'h7F007F00, 1'b1, 0, 4'd0,  1'b0};
    tv[1] = '{32'h7F00FF00, 1'b0, 1, 4'd15, 1'b1};
    tv[2] = '{32'h00000000, 1'b0, 7, 4'd8,  1'b1};
    tv[3] = '{32'hFFFFFFFF, 1'b0, 9, 4'd0,  1'b1};
    tv[4] = '{32'h7F017F01, 1'b0, 1, 4'd0,  1'b1};
    tv[5] = '{32'h7F0C7F30, 1'b0, 4, 4'd2,  1'b1};

    b1.start  = 1'b0;
    b3.start  = 1'b0;
    b1.exp_tt = '0;
    b3.exp_tt = TT_GOLD;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero1("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) sweep1(tv[i], 1'b0);

    // Longer settle on the SETTLE=3 instance
    @(negedge clk);
    d0 = done3;
    b3.start = 1'b1;
    acc = cyc + 1;
    e = '{TT_GOLD, 1'b1, 0, acc + 64, 4'd0, 1'b0};
    q3.push_back(e);
    @(negedge clk);
    b3.start = 1'b0;
    n = 0;
    while (done3 == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("settle3_done_seen", 64'(done3 != d0), 64'(1));

    // start while busy is ignored
    sweep1(tv[0], 1'b1);

    // Reset mid-sweep, then a clean sweep
    b1.exp_tt = TT_GOLD;
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    d0 = done1;
    n = 0;
    while (b1.m != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_reached_m7", 64'(b1.m), 64'(7));
    rst_n = 1'b0;
    #1;
    check_zero1("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midreset_no_done", 64'(done1 - d0), 64'(0));
    sweep1(tv[0], 1'b0);

    // Back-to-back sweeps with start held high
    b1.exp_tt = 32'h0;
    @(negedge clk);
    b1.start = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e = '{TT_GOLD, 1'b0, 7, acc + 32 + 34 * k, 4'd8, 1'b1};
      q1.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!b1.done && n < 100);
      chk("b2b_done_seen", 64'(b1.done), 64'(1));
      if (k < 2) begin
        repeat (2) @(negedge clk);
        chk("b2b_restart_tt_clear", 64'(b1.tt), 64'(0));
        chk("b2b_restart_err_clear", 64'(b1.err_cnt), 64'(0));
        chk("b2b_restart_busy", 64'(b1.busy), 64'(1));
      end else begin
        b1.start = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    chk("b2b_queue_empty", 64'(q1.size()), 64'(0));
    chk("b2b_idle_after", 64'(b1.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
